// File: rtl/uart_word_pkg.sv
// Shared types and helpers for the uart_word_link word sequencer.
// The optional per-byte retry feature is enabled by defining UART_WORD_RETRY_EN.
package uart_word_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        WAIT_RX,
        DONE
    } state_t;

    localparam int unsigned TX_BUSY_WAIT = 16;

    // Byte lane in the word for the idx-th byte on the wire.
    function automatic int unsigned byte_lane(input int unsigned idx,
                                              input int unsigned nbytes,
                                              input bit          msb_first);
        return msb_first ? (nbytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/uart_word_link_if.sv
// Signals between the word sequencer and the uart_transmitter/uart_receiver pair.
// master = sequencer side, slave = UART side.
interface uart_word_link_if;

    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_en;
    logic       tx_busy;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferror;
    logic       rx_perror;

    modport master (
        output tx_data, tx_wr, tx_en, rx_en,
        input  tx_busy, rx_data, rx_valid, rx_ferror, rx_perror
    );

    modport slave (
        input  tx_data, tx_wr, tx_en, rx_en,
        output tx_busy, rx_data, rx_valid, rx_ferror, rx_perror
    );

endinterface

// File: rtl/uart_word_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module uart_word_timeout #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_word_link.sv
// Word-level UART sequencer: sends WORD_BYTES bytes, reassembles the echoed bytes.
// Define UART_WORD_RETRY_EN to retry bad/timed-out bytes (adds retry_count).
module uart_word_link
    import uart_word_pkg::*;
#(
    parameter int unsigned               WORD_BYTES     = 2,
    parameter bit                        MSB_FIRST      = 1'b1,
    parameter int unsigned               TIMEOUT_CYCLES = 200000,
    parameter logic [8*WORD_BYTES-1:0]   ERR_PATTERN    = {WORD_BYTES{8'hBB}},
    parameter int unsigned               MAX_RETRY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*WORD_BYTES-1:0] word_in,
    output logic                    busy,
    uart_word_link_if.master        uart,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    output logic                    error
`ifdef UART_WORD_RETRY_EN
    ,
    output logic [7:0]              retry_count
`endif
);

    localparam int unsigned W       = 8 * WORD_BYTES;
    localparam int unsigned IDX_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > TX_BUSY_WAIT) ? TIMEOUT_CYCLES : TX_BUSY_WAIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    if (WORD_BYTES == 0 || WORD_BYTES > 8 || MAX_RETRY > 255) begin : g_param_check
        $error("uart_word_link: unsupported WORD_BYTES or MAX_RETRY");
    end

    state_t           state;
    logic [W-1:0]     word_q;
    logic [W-1:0]     assembled;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] lane;
    logic             err_acc;
    logic             rx_valid_q;
    logic             rx_rise;
    logic             rx_bad;
    logic             last_byte;
    logic             tmr_load;
    logic             tmr_tick;
    logic             tmr_expired;
    logic [CNT_W-1:0] tmr_val;
`ifdef UART_WORD_RETRY_EN
    logic [7:0]       retry_cnt;
    logic [7:0]       retry_total;
`endif

    assign lane      = IDX_W'(byte_lane(32'(byte_idx), WORD_BYTES, MSB_FIRST));
    assign rx_rise   = uart.rx_valid & ~rx_valid_q;
    assign rx_bad    = uart.rx_ferror | uart.rx_perror;
    assign last_byte = (byte_idx == IDX_W'(WORD_BYTES - 1));

    // One counter serves both the tx_busy-rise guard and the per-byte receive timeout.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_tick = (state == WAIT_HI) || (state == WAIT_RX);
        if (state == LOAD) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(TX_BUSY_WAIT - 1);
        end else if (state == WAIT_LO && !uart.tx_busy) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(TIMEOUT_CYCLES - 1);
        end
    end

    uart_word_timeout #(.WIDTH(CNT_W)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            uart.tx_wr   <= 1'b0;
            uart.tx_en   <= 1'b0;
            uart.rx_en   <= 1'b0;
            uart.tx_data <= '0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            error        <= 1'b0;
            word_q       <= '0;
            assembled    <= '0;
            byte_idx     <= '0;
            err_acc      <= 1'b0;
            rx_valid_q   <= 1'b0;
`ifdef UART_WORD_RETRY_EN
            retry_cnt    <= '0;
            retry_total  <= '0;
            retry_count  <= '0;
`endif
        end else begin
            rx_valid_q <= uart.rx_valid;
            uart.tx_wr <= 1'b0;
            word_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        word_q     <= word_in;
                        assembled  <= '0;
                        byte_idx   <= '0;
                        err_acc    <= 1'b0;
                        busy       <= 1'b1;
                        uart.tx_en <= 1'b1;
                        uart.rx_en <= 1'b1;
`ifdef UART_WORD_RETRY_EN
                        retry_cnt   <= '0;
                        retry_total <= '0;
`endif
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    uart.tx_data <= word_q[{lane, 3'b000} +: 8];
                    uart.tx_wr   <= 1'b1;
                    state        <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (uart.tx_busy) begin
                        state <= WAIT_LO;
                    end else if (tmr_expired) begin
                        err_acc <= 1'b1;
                        state   <= DONE;
                    end
                end
                WAIT_LO: begin
                    if (!uart.tx_busy) state <= WAIT_RX;
                end
                WAIT_RX: begin
                    // A byte arriving on the expiry cycle takes priority over the timeout.
                    if (rx_rise) begin
`ifdef UART_WORD_RETRY_EN
                        if (rx_bad && retry_cnt < 8'(MAX_RETRY)) begin
                            retry_cnt   <= retry_cnt + 8'd1;
                            retry_total <= retry_total + 8'd1;
                            state       <= LOAD;
                        end else
`endif
                        begin
                            assembled[{lane, 3'b000} +: 8] <= uart.rx_data;
                            err_acc <= err_acc | rx_bad;
                            if (last_byte) begin
                                state <= DONE;
                            end else begin
                                byte_idx <= byte_idx + IDX_W'(1);
`ifdef UART_WORD_RETRY_EN
                                retry_cnt <= '0;
`endif
                                state    <= LOAD;
                            end
                        end
                    end else if (tmr_expired) begin
`ifdef UART_WORD_RETRY_EN
                        if (retry_cnt < 8'(MAX_RETRY)) begin
                            retry_cnt   <= retry_cnt + 8'd1;
                            retry_total <= retry_total + 8'd1;
                            state       <= LOAD;
                        end else
`endif
                        begin
                            err_acc <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    word_out   <= err_acc ? ERR_PATTERN : assembled;
                    error      <= err_acc;
                    word_valid <= 1'b1;
                    busy       <= 1'b0;
`ifdef UART_WORD_RETRY_EN
                    retry_count <= retry_total;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
